hamming_minmax_engine: RTL and testbench
========================================

HAMMING_MINMAX_ENGINE -- requirements
Module: hamming_minmax_engine

Interface
REQ-001 Parameter: OP_BASE, 0, byte address of operand 0 in data memory.
REQ-002 Parameter: RES_ADDR, 64, byte address of min result; max result at RES_ADDR+1.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  run request, level, sampled only in IDLE.
REQ-006 Port: done  out  1  run complete, held high in DONE.
REQ-007 Port: mem_addr  out  8  data memory byte address.
REQ-008 Port: mem_rd_en  out  1  read strobe; memory returns mem_rdata one cycle later (synchronous read).
REQ-009 Port: mem_rdata  in  8  read data.
REQ-010 Port: mem_wr_en  out  1  write strobe, committed at the next rising edge.
REQ-011 Port: mem_wdata  out  8  write data.
REQ-012 Port: min_dist / max_dist  out  5 each  result distances.
REQ-013 Port: min_i, min_j, max_i, max_j  out  5 each  operand indices of the result pairs (i<j).

Function
REQ-014 Operand n (0..31) SHALL be {mem[OP_BASE+2n], mem[OP_BASE+2n+1]}; high byte at the even address.
REQ-015 FSM states SHALL be IDLE, LOAD, COMPUTE, WRITE, DONE.
REQ-016 IDLE: start=1 at edge E0 -> LOAD; start=0 -> stay in IDLE.
REQ-017 LOAD: issue reads at addresses OP_BASE+0..OP_BASE+63, one per cycle in cycles E0..E63; capture each returned byte into a 32x16 internal cache; LOAD -> COMPUTE at E65 after the last byte is captured.
REQ-018 COMPUTE: evaluate one pair per cycle in order (0,1),(0,2)..(0,31),(1,2)..(30,31), 496 cycles.
REQ-019 Distance SHALL be the popcount of (op_i XOR op_j), 5 bits, range 0..16.
REQ-020 Pair (0,1) SHALL unconditionally load both min and max, with their pair indices.
REQ-021 Each later pair SHALL update min only if dist<min, and max only if dist>max; strict compares, so ties keep the earliest pair in evaluation order.
REQ-022 WRITE: first cycle writes {3'b0,min_dist} to RES_ADDR; second cycle writes {3'b0,max_dist} to RES_ADDR+1; then -> DONE.
REQ-023 done SHALL first be high after edge E0+564.
REQ-024 DONE: done=1 and all result ports stable; start=0 -> IDLE with done=0; start=1 -> remain in DONE.
REQ-025 start changes outside IDLE/DONE SHALL be ignored.
REQ-026 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-027 Both strobes SHALL be 0 outside LOAD and WRITE respectively.
REQ-028 Result ports SHALL update during COMPUTE and hold their values through IDLE until the next LOAD begins.
REQ-029 Entering LOAD SHALL clear all result ports to 0.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, with done=0, all strobes 0, mem_addr=0, mem_wdata=0, and all result ports 0.
REQ-031 Reset mid-run SHALL abort the run with no further memory writes; the internal cache contents are don't-care.
REQ-032 The first start after reset is released SHALL perform a complete run.

Verification
REQ-033 All 32 operands 0x0000 -> mem[64]=0, mem[65]=0, min pair (0,1), max pair (0,1), done after E0+564.
REQ-034 All operands 0x0000 except op5=op9=0xFFFF -> min 0 pair (0,1); max 16 pair (0,5).
REQ-035 Operand n = 1<<(n mod 16) -> min 0 pair (0,16); max 2 pair (0,1); mem[64]=0, mem[65]=2.
REQ-036 reset pulsed low at E0+300 (during COMPUTE) -> done=0, ports 0, mem[64..65] unchanged; a new start then completes correctly.
REQ-037 start toggled during LOAD and COMPUTE -> no effect on timing; start held high after done -> done stays 1; start=0 -> IDLE next edge.
REQ-038 32 random operands -> mem[64], mem[65], and all pair indices match the bench model using first-occurrence strict compares.

Source files
------------

// File: rtl/hamming_minmax_engine.sv
// hamming_minmax_engine
//
// Loads 32 sixteen-bit operands from a byte-wide data memory, then finds
// the minimum and maximum Hamming distance over all 496 unordered pairs
// (i<j). The two distances go back to memory at RES_ADDR and RES_ADDR+1.
//
// The pair scan has two stages. The first stage reads both operands from
// the cache and computes their distance. The second stage compares that
// distance against the running min and max. The extra stage adds one
// drain cycle at the end of COMPUTE.
//
// Timing, where E0 is the edge that accepts start:
//   LOAD    E0 .. E65   reads in cycles 0..63, last byte captured at E65
//   COMPUTE E65 .. E562 496 pair issues plus one pipeline drain cycle
//   WRITE   E562 .. E564 min byte, then max byte
//   DONE    from E564
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-low
//   start      run request (level); sampled in IDLE and DONE
//   done       high while in DONE
//   mem_addr   data memory byte address
//   mem_rd_en  read strobe; mem_rdata is valid one cycle later
//   mem_rdata  read data
//   mem_wr_en  write strobe
//   mem_wdata  write data
//   min_dist, min_i, min_j  smallest distance and its pair
//   max_dist, max_i, max_j  largest distance and its pair
module hamming_minmax_engine #(
    parameter int OP_BASE  = 0,
    parameter int RES_ADDR = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    output logic [4:0] min_dist,
    output logic [4:0] max_dist,
    output logic [4:0] min_i,
    output logic [4:0] min_j,
    output logic [4:0] max_i,
    output logic [4:0] max_j
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [8:0] NUM_PAIRS = 9'd496;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int k = 0; k < 16; k++) begin
            c = c + {4'b0, v[k]};
        end
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [6:0] ld_cnt_q, ld_cnt_d;
    logic [8:0] cnt_q, cnt_d;
    logic [4:0] i_q, i_d, j_q, j_d;
    logic       wr_phase_q, wr_phase_d;

    logic       vld_p1_q, vld_p1_d;
    logic [4:0] dist_p1_q, dist_p1_d;
    logic [4:0] pi_p1_q, pi_p1_d;
    logic [4:0] pj_p1_q, pj_p1_d;

    logic [4:0] min_dist_q, min_dist_d, max_dist_q, max_dist_d;
    logic [4:0] min_i_q, min_i_d, min_j_q, min_j_d;
    logic [4:0] max_i_q, max_i_d, max_j_q, max_j_d;

    // Byte cache. Operand n occupies bytes 2n (high) and 2n+1 (low).
    logic [7:0]  cache_q [64];
    logic [5:0]  cap_idx;
    logic [15:0] op_a, op_b;

    // The read issued in cycle k returns in cycle k+1, so the capture
    // index trails the load counter by one.
    assign cap_idx = ld_cnt_q[5:0] - 6'd1;
    assign op_a    = {cache_q[{i_q, 1'b0}], cache_q[{i_q, 1'b1}]};
    assign op_b    = {cache_q[{j_q, 1'b0}], cache_q[{j_q, 1'b1}]};

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && ld_cnt_q != 7'd0) begin
            cache_q[cap_idx] <= mem_rdata;
        end
    end

    // ---- stage 0: control and pair issue ----
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        wr_phase_d = wr_phase_q;
        vld_p1_d   = 1'b0;
        dist_p1_d  = popcount16(op_a ^ op_b);
        pi_p1_d    = i_q;
        pj_p1_d    = j_q;
        min_dist_d = min_dist_q;
        max_dist_d = max_dist_q;
        min_i_d    = min_i_q;
        min_j_d    = min_j_q;
        max_i_d    = max_i_q;
        max_j_d    = max_j_q;

        // ---- stage 1: running min/max update ----
        if (vld_p1_q) begin
            if (pi_p1_q == 5'd0 && pj_p1_q == 5'd1) begin
                // The first pair seeds both results unconditionally.
                min_dist_d = dist_p1_q;
                min_i_d    = pi_p1_q;
                min_j_d    = pj_p1_q;
                max_dist_d = dist_p1_q;
                max_i_d    = pi_p1_q;
                max_j_d    = pj_p1_q;
            end else begin
                // Strict compares, so on a tie the earlier pair stays.
                if (dist_p1_q < min_dist_q) begin
                    min_dist_d = dist_p1_q;
                    min_i_d    = pi_p1_q;
                    min_j_d    = pj_p1_q;
                end
                if (dist_p1_q > max_dist_q) begin
                    max_dist_d = dist_p1_q;
                    max_i_d    = pi_p1_q;
                    max_j_d    = pj_p1_q;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    ld_cnt_d   = 7'd0;
                    min_dist_d = 5'd0;
                    max_dist_d = 5'd0;
                    min_i_d    = 5'd0;
                    min_j_d    = 5'd0;
                    max_i_d    = 5'd0;
                    max_j_d    = 5'd0;
                end
            end
            S_LOAD: begin
                ld_cnt_d = ld_cnt_q + 7'd1;
                if (ld_cnt_q == 7'd64) begin
                    state_d = S_COMPUTE;
                    cnt_d   = 9'd0;
                    i_d     = 5'd0;
                    j_d     = 5'd1;
                end
            end
            S_COMPUTE: begin
                cnt_d    = cnt_q + 9'd1;
                vld_p1_d = (cnt_q < NUM_PAIRS);
                if (j_q == 5'd31) begin
                    i_d = i_q + 5'd1;
                    j_d = i_q + 5'd2;
                end else begin
                    j_d = j_q + 5'd1;
                end
                // cnt_q == NUM_PAIRS is the drain cycle for the last pair.
                if (cnt_q == NUM_PAIRS) begin
                    state_d    = S_WRITE;
                    wr_phase_d = 1'b0;
                end
            end
            S_WRITE: begin
                wr_phase_d = 1'b1;
                if (wr_phase_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        done      = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (ld_cnt_q < 7'd64) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = 8'(OP_BASE) + {2'b0, ld_cnt_q[5:0]};
                end
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                if (wr_phase_q) begin
                    mem_addr  = 8'(RES_ADDR) + 8'd1;
                    mem_wdata = {3'b0, max_dist_q};
                end else begin
                    mem_addr  = 8'(RES_ADDR);
                    mem_wdata = {3'b0, min_dist_q};
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Control state and results reset; pipeline data does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= 7'd0;
            cnt_q      <= 9'd0;
            i_q        <= 5'd0;
            j_q        <= 5'd0;
            wr_phase_q <= 1'b0;
            vld_p1_q   <= 1'b0;
            min_dist_q <= 5'd0;
            max_dist_q <= 5'd0;
            min_i_q    <= 5'd0;
            min_j_q    <= 5'd0;
            max_i_q    <= 5'd0;
            max_j_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            wr_phase_q <= wr_phase_d;
            vld_p1_q   <= vld_p1_d;
            min_dist_q <= min_dist_d;
            max_dist_q <= max_dist_d;
            min_i_q    <= min_i_d;
            min_j_q    <= min_j_d;
            max_i_q    <= max_i_d;
            max_j_q    <= max_j_d;
        end
    end

    always_ff @(posedge clk) begin
        dist_p1_q <= dist_p1_d;
        pi_p1_q   <= pi_p1_d;
        pj_p1_q   <= pj_p1_d;
    end

    assign min_dist = min_dist_q;
    assign max_dist = max_dist_q;
    assign min_i    = min_i_q;
    assign min_j    = min_j_q;
    assign max_i    = max_i_q;
    assign max_j    = max_j_q;

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Bench for hamming_minmax_engine: byte memory with synchronous read,
// directed and randomized operand sets, and a pairwise reference model.
module tb_hamming_minmax_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [4:0] min_dist, max_dist, min_i, min_j, max_i, max_j;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    logic [7:0]  img [256];
    logic        tb_load = 1'b0;
    logic [15:0] ops [32];

    int rd_cnt = 0;
    int wr_cnt = 0;
    int excl   = 0;

    hamming_minmax_engine #(.OP_BASE(0), .RES_ADDR(64)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .min_dist(min_dist), .max_dist(max_dist),
        .min_i(min_i), .min_j(min_j), .max_i(max_i), .max_j(max_j)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= img[k];
        end else begin
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (mem_rd_en && mem_wr_en) excl++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: scan every pair in evaluation order, strict compares.
    task automatic model(output int mn, output int mni, output int mnj,
                         output int mx, output int mxi, output int mxj);
        bit first = 1'b1;
        mn = 0; mni = 0; mnj = 0; mx = 0; mxi = 0; mxj = 0;
        for (int i = 0; i < 32; i++) begin
            for (int j = i + 1; j < 32; j++) begin
                int d;
                d = $countones(ops[i] ^ ops[j]);
                if (first) begin
                    mn = d; mni = i; mnj = j; mx = d; mxi = i; mxj = j;
                    first = 1'b0;
                end else begin
                    if (d < mn) begin mn = d; mni = i; mnj = j; end
                    if (d > mx) begin mx = d; mxi = i; mxj = j; end
                end
            end
        end
    endtask

    task automatic load_image();
        @(negedge clk);
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        for (int n = 0; n < 32; n++) begin
            img[2*n]   = ops[n][15:8];
            img[2*n+1] = ops[n][7:0];
        end
        img[64] = 8'hAA;
        img[65] = 8'h55;
        tb_load = 1'b1;
        @(negedge clk);
        tb_load = 1'b0;
    endtask

    task automatic run(input string tag, input bit toggle, input bit hold);
        int n, mn, mni, mnj, mx, mxi, mxj;
        model(mn, mni, mnj, mx, mxi, mxj);
        load_image();
        rd_cnt = 0; wr_cnt = 0; excl = 0;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        check_eq({tag, "_clr"}, {2'b0, min_dist, max_dist, min_i, min_j, max_i, max_j}, 32'd0);
        start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        while (!done && n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (toggle) start = 1'($urandom_range(0, 1));
        end
        start = hold;
        check_eq({tag, "_lat"}, n, 564);
        check_eq({tag, "_mind"}, min_dist, mn);
        check_eq({tag, "_minij"}, {min_i, min_j}, {5'(mni), 5'(mnj)});
        check_eq({tag, "_maxd"}, max_dist, mx);
        check_eq({tag, "_maxij"}, {max_i, max_j}, {5'(mxi), 5'(mxj)});
        check_eq({tag, "_m64"}, mem[64], mn);
        check_eq({tag, "_m65"}, mem[65], mx);
        check_eq({tag, "_rds"}, rd_cnt, 64);
        check_eq({tag, "_wrs"}, wr_cnt, 2);
        check_eq({tag, "_excl"}, excl, 0);
        if (hold) begin
            repeat (3) @(negedge clk);
            check_eq({tag, "_hold"}, done, 1);
            start = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_idle"}, done, 0);
        check_eq({tag, "_keep"}, {min_dist, max_dist}, {5'(mn), 5'(mx)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_strb"}, {mem_rd_en, mem_wr_en}, 0);
        check_eq({tag, "_addr"}, {mem_addr, mem_wdata}, 0);
        check_eq({tag, "_res"}, {2'b0, min_dist, max_dist, min_i, min_j, max_i, max_j}, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk);

        // All zero operands
        for (int k = 0; k < 32; k++) ops[k] = 16'h0000;
        run("zero", 1'b0, 1'b0);

        // Two all-ones operands in a zero field
        ops[5] = 16'hFFFF; ops[9] = 16'hFFFF;
        run("ones59", 1'b0, 1'b0);

        // One-hot operands repeating every 16
        for (int k = 0; k < 32; k++) ops[k] = 16'(1 << (k % 16));
        run("onehot", 1'b0, 1'b0);

        // Reset during COMPUTE
        for (int k = 0; k < 32; k++) ops[k] = 16'($urandom);
        load_image();
        wr_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("abort_m64", mem[64], 8'hAA);
        check_eq("abort_m65", mem[65], 8'h55);
        check_eq("abort_wrs", wr_cnt, 0);
        check_eq("abort_idle", done, 0);
        run("after_abort", 1'b0, 1'b0);

        // start toggled mid-run, then held high in DONE
        for (int k = 0; k < 32; k++) ops[k] = 16'($urandom);
        run("toggle", 1'b1, 1'b1);

        // Random operands, including sets dense with ties
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) ops[k] = 16'($urandom);
            run($sformatf("rnd%0d", r), 1'b0, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 32; k++) ops[k] = 16'($urandom_range(0, 7) * 16'h1111);
            run($sformatf("tie%0d", r), 1'b0, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
